// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide controller: funct3 codes,
// FSM state encoding and the RISC-V corner-case result constants.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/md_special_case.sv
// Combinational RISC-V divide corner cases (divide-by-zero, signed overflow)
// that are resolved without starting the iterative unit.
module md_special_case
  import muldiv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  logic is_rem;
  logic div_by_zero;
  logic overflow;

  always_comb begin
    is_rem      = funct3[1];
    div_by_zero = funct3[2] & (rs2 == '0);
    overflow    = ((funct3 == MD_DIV) | (funct3 == MD_REM)) &
                  (rs1 == INT_MIN) & (rs2 == ALL_ONES);
    hit         = div_by_zero | overflow;
    result      = '0;
    // Zero divisor takes precedence: quotient all-ones, remainder is the dividend
    if (div_by_zero) begin
      result = is_rem ? rs1 : ALL_ONES;
    end else if (overflow) begin
      result = is_rem ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// EX-stage sequencer for the iterative RV32M unit: captures operands, runs the
// start/done handshake, holds the pipeline and presents the result.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_MulDivOp,
  input  logic [2:0]      EX_Funct3,
  input  logic [XLEN-1:0] EX_RS1_Data,
  input  logic [XLEN-1:0] EX_RS2_Data,
  input  logic            Flush,
  input  logic            Pipe_Hold,
  input  logic            MD_Done,
  input  logic [XLEN-1:0] MD_Result,
  output logic            MD_Start,
  output logic            MD_Kill,
  output logic [2:0]      MD_Op,
  output logic [XLEN-1:0] MD_A,
  output logic [XLEN-1:0] MD_B,
  output logic            MulDiv_Stall,
  output logic            MulDiv_Valid,
  output logic [XLEN-1:0] MulDiv_Result,
  output logic            MulDiv_Err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            issue;
  logic            sc_hit;
  logic [XLEN-1:0] sc_result;

  assign issue = EX_MulDivOp & ~Flush;

  md_special_case u_special (
    .funct3 (EX_Funct3),
    .rs1    (EX_RS1_Data),
    .rs2    (EX_RS2_Data),
    .hit    (sc_hit),
    .result (sc_result)
  );

  // Stall must be combinational so the op is frozen in its first EX cycle
  always_comb begin
    MulDiv_Stall = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    MulDiv_Stall = issue;
        BUSY:    MulDiv_Stall = 1'b1;
        default: MulDiv_Stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      MD_Start      <= 1'b0;
      MD_Kill       <= 1'b0;
      MD_Op         <= '0;
      MD_A          <= '0;
      MD_B          <= '0;
      MulDiv_Valid  <= 1'b0;
      MulDiv_Result <= '0;
      MulDiv_Err    <= 1'b0;
    end else begin
      MD_Start   <= 1'b0;
      MD_Kill    <= 1'b0;
      MulDiv_Err <= 1'b0;
      if (Flush) begin
        MD_Kill      <= (state == BUSY);
        MulDiv_Valid <= 1'b0;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (EX_MulDivOp) begin
              MD_Op <= EX_Funct3;
              MD_A  <= EX_RS1_Data;
              MD_B  <= EX_RS2_Data;
              if (sc_hit) begin
                MulDiv_Result <= sc_result;
                MulDiv_Valid  <= 1'b1;
                state         <= DONE;
              end else begin
                cnt      <= '0;
                MD_Start <= 1'b1;
                state    <= BUSY;
              end
            end
          end
          BUSY: begin
            cnt <= cnt + CNT_W'(1);
            // A Done arriving on the timeout cycle still wins
            if (MD_Done) begin
              MulDiv_Result <= MD_Result;
              MulDiv_Valid  <= 1'b1;
              state         <= DONE;
            end else if (cnt == CNT_LAST) begin
              MulDiv_Result <= '0;
              MulDiv_Valid  <= 1'b1;
              MulDiv_Err    <= 1'b1;
              MD_Kill       <= 1'b1;
              state         <= DONE;
            end
          end
          DONE: begin
            if (!Pipe_Hold) begin
              MulDiv_Valid <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Randomized scoreboard bench for muldiv_controller with a behavioural RV32M
// unit model and arithmetic reference model.
module tb_muldiv_controller;

  localparam int unsigned TB_TIMEOUT = 8;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        EX_MulDivOp;
  logic [2:0]  EX_Funct3;
  logic [31:0] EX_RS1_Data;
  logic [31:0] EX_RS2_Data;
  logic        Flush;
  logic        Pipe_Hold;
  logic        MD_Done;
  logic [31:0] MD_Result;
  logic        MD_Start;
  logic        MD_Kill;
  logic [2:0]  MD_Op;
  logic [31:0] MD_A;
  logic [31:0] MD_B;
  logic        MulDiv_Stall;
  logic        MulDiv_Valid;
  logic [31:0] MulDiv_Result;
  logic        MulDiv_Err;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   n_kill = 0;
  int   unit_lat = 1;
  bit   unit_mute = 1'b0;

  muldiv_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EX_MulDivOp   (EX_MulDivOp),
    .EX_Funct3     (EX_Funct3),
    .EX_RS1_Data   (EX_RS1_Data),
    .EX_RS2_Data   (EX_RS2_Data),
    .Flush         (Flush),
    .Pipe_Hold     (Pipe_Hold),
    .MD_Done       (MD_Done),
    .MD_Result     (MD_Result),
    .MD_Start      (MD_Start),
    .MD_Kill       (MD_Kill),
    .MD_Op         (MD_Op),
    .MD_A          (MD_A),
    .MD_B          (MD_B),
    .MulDiv_Stall  (MulDiv_Stall),
    .MulDiv_Valid  (MulDiv_Valid),
    .MulDiv_Result (MulDiv_Result),
    .MulDiv_Err    (MulDiv_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M semantics computed with plain wide arithmetic
  function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    int          ia;
    int          ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'd0, b});
    ia = signed'(a);
    ib = signed'(b);
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1'b1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Behavioural iterative unit: answers a Start after unit_lat cycles
  initial begin : unit_model
    int          lat;
    logic [31:0] res;
    MD_Done   = 1'b0;
    MD_Result = 32'd0;
    forever begin
      @(negedge clk);
      if (MD_Start && !unit_mute) begin
        lat = unit_lat;
        res = rv32m(MD_Op, MD_A, MD_B);
        repeat (lat) @(posedge clk);
        #1;
        MD_Done   = 1'b1;
        MD_Result = res;
        @(posedge clk);
        #1;
        MD_Done   = 1'b0;
        MD_Result = $urandom();
      end
    end
  end

  // Monitor: pops the scoreboard on each new Valid and watches handshake pulses
  initial begin : monitor
    bit   prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (MD_Start) n_start++;
      if (MD_Kill) n_kill++;
      if (MD_Start || MD_Kill) chk("start_kill_exclusive", 32'(MD_Start & MD_Kill), 32'd0);
      if (MulDiv_Valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(MulDiv_Valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", MulDiv_Result, e.res);
          chk("err_pulse", 32'(MulDiv_Err), 32'(e.err));
          chk("kill_with_err", 32'(MD_Kill), 32'(e.err));
        end
      end
      prev_valid = MulDiv_Valid;
    end
  end

  // Issue one op; starts and ends at posedge+1
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input bit mute);
    exp_t e;
    int   exp_stall;
    int   stalls;
    int   s0;
    bit   sp;
    sp = is_special(f, a, b);
    if (sp) begin
      e.res = rv32m(f, a, b); e.err = 1'b0; exp_stall = 1;
    end else if (mute) begin
      e.res = 32'd0; e.err = 1'b1; exp_stall = 1 + int'(TB_TIMEOUT);
    end else begin
      e.res = rv32m(f, a, b); e.err = 1'b0; exp_stall = 2 + lat;
    end
    exp_q.push_back(e);
    unit_lat    = lat;
    unit_mute   = mute;
    s0          = n_start;
    Pipe_Hold   = (hold > 0);
    EX_MulDivOp = 1'b1;
    EX_Funct3   = f;
    EX_RS1_Data = a;
    EX_RS2_Data = b;
    stalls      = 0;
    @(negedge clk);
    while (MulDiv_Stall && stalls < 300) begin
      stalls++;
      @(posedge clk);
      #1;
      EX_RS1_Data = $urandom();
      EX_RS2_Data = $urandom();
      @(negedge clk);
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("valid_in_done", 32'(MulDiv_Valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(MulDiv_Valid), 32'd1);
      chk("hold_result", MulDiv_Result, e.res);
      chk("hold_stall", 32'(MulDiv_Stall), 32'd0);
      @(posedge clk);
      #1;
      if (i == hold - 1) Pipe_Hold = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk("valid_after_hold", 32'(MulDiv_Valid), 32'd1);
    @(posedge clk);
    #1;
    EX_MulDivOp = 1'b0;
    EX_Funct3   = 3'($urandom());
    @(negedge clk);
    chk("valid_drop", 32'(MulDiv_Valid), 32'd0);
    chk("start_pulses", 32'(n_start - s0), sp ? 32'd0 : 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int k0;
    rst_n       = 1'b0;
    EX_MulDivOp = 1'b1;
    EX_Funct3   = 3'b000;
    EX_RS1_Data = 32'd5;
    EX_RS2_Data = 32'd9;
    Flush       = 1'b0;
    Pipe_Hold   = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(MulDiv_Stall), 32'd0);
    chk("rst_valid", 32'(MulDiv_Valid), 32'd0);
    chk("rst_result", MulDiv_Result, 32'd0);
    chk("rst_md_a", MD_A, 32'd0);
    chk("rst_start", 32'(MD_Start), 32'd0);
    @(posedge clk);
    #1;
    EX_MulDivOp = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;

    run_op(3'b000, 32'd6, 32'd7, 4, 0, 1'b0);
    run_op(3'b101, 32'd100, 32'd0, 1, 0, 1'b0);
    run_op(3'b110, 32'h0000_DEAD, 32'd0, 1, 0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1'b0);

    // Flush in the second BUSY cycle; unit answers late
    unit_lat    = 3;
    unit_mute   = 1'b0;
    k0          = n_kill;
    EX_MulDivOp = 1'b1;
    EX_Funct3   = 3'b000;
    EX_RS1_Data = 32'd3;
    EX_RS2_Data = 32'd5;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_start", 32'(MD_Start), 32'd1);
    @(posedge clk); #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush       = 1'b0;
    EX_MulDivOp = 1'b0;
    @(negedge clk);
    chk("flush_kill", 32'(MD_Kill), 32'd1);
    chk("flush_valid", 32'(MulDiv_Valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("flush_no_valid", 32'(MulDiv_Valid), 32'd0);
    end
    chk("flush_kill_count", 32'(n_kill - k0), 32'd1);
    @(posedge clk); #1;

    run_op(3'b000, 32'h0000_1234, 32'd1, 2, 3, 1'b0);
    run_op(3'b000, 32'd11, 32'd13, 1, 0, 1'b1);

    // Asynchronous reset in the middle of BUSY
    unit_lat    = 6;
    unit_mute   = 1'b0;
    EX_MulDivOp = 1'b1;
    EX_Funct3   = 3'b000;
    EX_RS1_Data = 32'd9;
    EX_RS2_Data = 32'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(MulDiv_Stall), 32'd0);
    chk("arst_md_a", MD_A, 32'd0);
    chk("arst_md_op_b", {MD_B[28:0], MD_Op}, 32'd0);
    chk("arst_valid", 32'(MulDiv_Valid), 32'd0);
    chk("arst_start_kill", 32'({MD_Start, MD_Kill, MulDiv_Err}), 32'd0);
    EX_MulDivOp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom()), pick(), pick(), int'($urandom_range(1, 5)),
             int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
